// File: rtl/l2_miss_request_queue.sv
`timescale 1ns/1ps
// L1->L2 miss request queue: in-order FIFO of fills/writebacks,
// read merging, outstanding-read tracker and fill return path.
module l2_miss_request_queue #(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 64,
  parameter int DEPTH      = 4,
  parameter int MAX_OUTST  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wb,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              l2_valid,
  input  logic              l2_ready,
  output logic              l2_wb,
  output logic [ADDR_W-1:0] l2_addr,
  input  logic              l2_fill_valid,
  output logic              fill_valid,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [15:0]       rd_cnt,
  output logic [15:0]       wb_cnt,
  output logic [15:0]       merge_cnt,
  output logic              err_fill
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TP_W  =
    (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int TC_W  = $clog2(MAX_OUTST + 1);

  localparam logic [CNT_W-1:0] FULL =
    CNT_W'(DEPTH);
  localparam logic [TC_W-1:0] TMAX =
    TC_W'(MAX_OUTST);
  localparam logic [TP_W-1:0] TLAST =
    TP_W'(MAX_OUTST - 1);
  localparam logic [ADDR_W-1:0] LMASK =
    ~ADDR_W'(LINE_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_STALL
  } state_t;

  // request FIFO
  logic              r_q_wb   [DEPTH];
  logic [ADDR_W-1:0] r_q_addr [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_cnt;

  // outstanding read tracker
  logic [ADDR_W-1:0] r_t_addr [MAX_OUTST];
  logic [TP_W-1:0]   r_t_rd;
  logic [TP_W-1:0]   r_t_wr;
  logic [TC_W-1:0]   r_t_cnt;

  state_t            r_state;
  logic              r_l2_valid;
  logic              r_l2_wb;
  logic [ADDR_W-1:0] r_l2_addr;
  logic              r_fill_valid;
  logic [ADDR_W-1:0] r_fill_addr;
  logic [15:0]       r_rd_cnt;
  logic [15:0]       r_wb_cnt;
  logic [15:0]       r_merge_cnt;
  logic              r_err;

  logic [ADDR_W-1:0] w_line;
  logic              w_match;
  logic              w_acc;
  logic              w_merge;
  logic              w_push;
  logic              w_pop;
  logic              w_hold;
  logic              w_t_pop;
  logic              w_t_push;
  logic [CNT_W-1:0]  w_cnt_mid;
  logic [TC_W-1:0]   w_t_cnt_nx;
  logic              w_nh_valid;
  logic              w_nh_wb;
  logic [ADDR_W-1:0] w_nh_addr;
  state_t            w_state_nx;

  assign w_line    = req_addr & LMASK;
  assign req_ready = (r_cnt != FULL);
  assign w_acc     = req_valid && req_ready;
  assign w_merge   = w_acc && !req_wb && w_match;
  assign w_push    = w_acc && !w_merge;
  assign w_pop     = (r_state == S_ISSUE) && l2_ready;
  assign w_hold    = (r_state == S_ISSUE) && !l2_ready;
  assign w_t_pop   = l2_fill_valid && (r_t_cnt != '0);
  assign w_t_push  = w_pop && !r_l2_wb;
  assign w_cnt_mid = r_cnt - CNT_W'(w_pop);
  assign w_t_cnt_nx = r_t_cnt - TC_W'(w_t_pop)
                    + TC_W'(w_t_push);

  // merge search over queued (pre-pop) reads
  always_comb begin
    w_match = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CNT_W'(k) < r_cnt) &&
          !r_q_wb[r_rd_ptr + PTR_W'(k)] &&
          (r_q_addr[r_rd_ptr + PTR_W'(k)] == w_line))
        w_match = 1'b1;
    end
  end

  // head of the FIFO as it will look after this edge
  always_comb begin
    w_nh_valid = 1'b0;
    w_nh_wb    = 1'b0;
    w_nh_addr  = '0;
    if (w_cnt_mid != '0) begin
      w_nh_valid = 1'b1;
      w_nh_wb    = r_q_wb[r_rd_ptr + PTR_W'(w_pop)];
      w_nh_addr  = r_q_addr[r_rd_ptr + PTR_W'(w_pop)];
    end else if (w_push) begin
      w_nh_valid = 1'b1;
      w_nh_wb    = req_wb;
      w_nh_addr  = w_line;
    end
  end

  // issue decision from post-edge head and tracker level
  always_comb begin
    w_state_nx = S_IDLE;
    if (w_hold)
      w_state_nx = S_ISSUE;
    else if (!w_nh_valid)
      w_state_nx = S_IDLE;
    else if (!w_nh_wb && (w_t_cnt_nx == TMAX))
      w_state_nx = S_STALL;
    else
      w_state_nx = S_ISSUE;
  end

  // request FIFO storage and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q_wb[i]   <= 1'b0;
        r_q_addr[i] <= '0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_q_wb[r_wr_ptr]   <= req_wb;
        r_q_addr[r_wr_ptr] <= w_line;
        r_wr_ptr           <= r_wr_ptr + 1'b1;
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      r_cnt <= w_cnt_mid + CNT_W'(w_push);
    end
  end

  // outstanding tracker: fill pops before issue pushes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_OUTST; i++)
        r_t_addr[i] <= '0;
      r_t_rd  <= '0;
      r_t_wr  <= '0;
      r_t_cnt <= '0;
    end else begin
      if (w_t_pop)
        r_t_rd <= (r_t_rd == TLAST) ? '0
                : r_t_rd + 1'b1;
      if (w_t_push) begin
        r_t_addr[r_t_wr] <= r_l2_addr;
        r_t_wr <= (r_t_wr == TLAST) ? '0
                : r_t_wr + 1'b1;
      end
      r_t_cnt <= w_t_cnt_nx;
    end
  end

  // issue FSM with registered L2 request outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_l2_valid <= 1'b0;
      r_l2_wb    <= 1'b0;
      r_l2_addr  <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_l2_valid <= (w_state_nx == S_ISSUE);
      if (!w_hold) begin
        if (w_state_nx == S_ISSUE) begin
          r_l2_wb   <= w_nh_wb;
          r_l2_addr <= w_nh_addr;
        end else begin
          r_l2_wb   <= 1'b0;
          r_l2_addr <= '0;
        end
      end
    end
  end

  // fill pulse, sticky error and saturating counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill_valid <= 1'b0;
      r_fill_addr  <= '0;
      r_err        <= 1'b0;
      r_rd_cnt     <= '0;
      r_wb_cnt     <= '0;
      r_merge_cnt  <= '0;
    end else begin
      r_fill_valid <= w_t_pop;
      if (w_t_pop)
        r_fill_addr <= r_t_addr[r_t_rd];
      if (l2_fill_valid && (r_t_cnt == '0))
        r_err <= 1'b1;
      if (w_pop && !r_l2_wb && (r_rd_cnt != 16'hFFFF))
        r_rd_cnt <= r_rd_cnt + 16'd1;
      if (w_pop && r_l2_wb && (r_wb_cnt != 16'hFFFF))
        r_wb_cnt <= r_wb_cnt + 16'd1;
      if (w_merge && (r_merge_cnt != 16'hFFFF))
        r_merge_cnt <= r_merge_cnt + 16'd1;
    end
  end

  assign l2_valid   = r_l2_valid;
  assign l2_wb      = r_l2_wb;
  assign l2_addr    = r_l2_addr;
  assign fill_valid = r_fill_valid;
  assign fill_addr  = r_fill_addr;
  assign rd_cnt     = r_rd_cnt;
  assign wb_cnt     = r_wb_cnt;
  assign merge_cnt  = r_merge_cnt;
  assign err_fill   = r_err;

endmodule

// File: tb/tb_l2_miss_request_queue.sv
`timescale 1ns/1ps
// Bench for l2_miss_request_queue: queue-level reference
// model feeding a scoreboard checked by a monitor.
module tb_l2_miss_request_queue;

  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wb = 1'b0;
  logic [31:0] req_addr = '0;
  logic        l2_valid;
  logic        l2_ready = 1'b0;
  logic        l2_wb;
  logic [31:0] l2_addr;
  logic        l2_fill_valid = 1'b0;
  logic        fill_valid;
  logic [31:0] fill_addr;
  logic [15:0] rd_cnt;
  logic [15:0] wb_cnt;
  logic [15:0] merge_cnt;
  logic        err_fill;

  l2_miss_request_queue #(
    .ADDR_W(32), .LINE_BYTES(64),
    .DEPTH(DEPTH), .MAX_OUTST(MAXO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wb(req_wb), .req_addr(req_addr),
    .l2_valid(l2_valid), .l2_ready(l2_ready),
    .l2_wb(l2_wb), .l2_addr(l2_addr),
    .l2_fill_valid(l2_fill_valid),
    .fill_valid(fill_valid), .fill_addr(fill_addr),
    .rd_cnt(rd_cnt), .wb_cnt(wb_cnt),
    .merge_cnt(merge_cnt), .err_fill(err_fill)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wb;
    logic [31:0] line;
  } req_t;

  req_t        exp_issue[$];
  logic [31:0] outst[$];
  logic [31:0] exp_fill[$];
  int          m_rd, m_wb, m_mg;
  logic        exp_err;
  logic        m_hs;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // reference model: queue semantics, updated each edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_issue.delete();
      outst.delete();
      exp_fill.delete();
      m_rd = 0; m_wb = 0; m_mg = 0;
      exp_err = 1'b0;
    end else begin
      if (req_valid && exp_issue.size() < DEPTH) begin
        automatic logic [31:0] ln = req_addr & 32'hFFFF_FFC0;
        automatic logic mg = 1'b0;
        if (!req_wb)
          foreach (exp_issue[i])
            if (!exp_issue[i].wb && exp_issue[i].line == ln)
              mg = 1'b1;
        if (mg) m_mg = (m_mg < 65535) ? m_mg + 1 : m_mg;
        else exp_issue.push_back('{req_wb, ln});
      end
      if (l2_fill_valid) begin
        if (outst.size() != 0)
          exp_fill.push_back(outst.pop_front());
        else
          exp_err = 1'b1;
      end
      if (m_hs && exp_issue.size() != 0) begin
        automatic req_t e = exp_issue.pop_front();
        if (e.wb) m_wb = (m_wb < 65535) ? m_wb + 1 : m_wb;
        else begin
          outst.push_back(e.line);
          m_rd = (m_rd < 65535) ? m_rd + 1 : m_rd;
        end
      end
    end
  end

  // monitor: compares DUT outputs against the scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      m_hs = 1'b0;
    end else begin
      automatic logic ev = exp_issue.size() != 0 &&
        (exp_issue[0].wb || outst.size() < MAXO);
      m_hs = l2_valid && l2_ready;
      chk("l2_valid", 64'(l2_valid), 64'(ev));
      if (l2_valid && exp_issue.size() != 0) begin
        chk("l2_addr", 64'(l2_addr), 64'(exp_issue[0].line));
        chk("l2_wb", 64'(l2_wb), 64'(exp_issue[0].wb));
      end
      chk("req_ready", 64'(req_ready),
          64'(exp_issue.size() < DEPTH));
      chk("fill_valid", 64'(fill_valid),
          64'(exp_fill.size() != 0));
      if (exp_fill.size() != 0) begin
        automatic logic [31:0] fa = exp_fill.pop_front();
        if (fill_valid) chk("fill_addr", 64'(fill_addr), 64'(fa));
      end
      chk("rd_cnt", 64'(rd_cnt), 64'(m_rd));
      chk("wb_cnt", 64'(wb_cnt), 64'(m_wb));
      chk("merge_cnt", 64'(merge_cnt), 64'(m_mg));
      chk("err_fill", 64'(err_fill), 64'(exp_err));
    end
  end

  task automatic cyc(input logic rv, input logic wb,
                     input logic [31:0] a,
                     input logic rdy, input logic fv);
    req_valid = rv; req_wb = wb; req_addr = a;
    l2_ready = rdy; l2_fill_valid = fv;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    automatic logic done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      cyc(0, 0, 0, 1, outst.size() != 0);
      done = exp_issue.size() == 0 && outst.size() == 0
          && exp_fill.size() == 0;
    end
    chk("drain_done", 64'(done), 64'd1);
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] b;
    case ($urandom_range(0, 4))
      0: b = 32'h0000_1000;
      1: b = 32'h0000_2040;
      2: b = 32'hABCD_0000;
      3: b = 32'h1234_5640;
      default: b = $urandom & 32'hFFFF_FFC0;
    endcase
    return b | 32'($urandom_range(0, 63));
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_l2_valid", 64'(l2_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_fill_valid", 64'(fill_valid), 64'd0);
    chk("rst_rd_cnt", 64'(rd_cnt), 64'd0);
    chk("rst_err", 64'(err_fill), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single read, 1-cycle latency, line aligned
    cyc(1, 0, 32'h1234_5678, 1, 0);
    chk("t1_valid", 64'(l2_valid), 64'd1);
    chk("t1_addr", 64'(l2_addr), 64'h1234_5640);
    cyc(0, 0, 0, 1, 0);
    chk("t1_rd_cnt", 64'(rd_cnt), 64'd1);

    // fill queue while L2 stalls, then burst issue
    cyc(1, 1, 32'h0000_0100, 0, 0);
    cyc(1, 1, 32'h0000_0200, 0, 0);
    cyc(1, 1, 32'h0000_0300, 0, 0);
    cyc(1, 1, 32'h0000_0400, 0, 0);
    chk("t2_full", 64'(req_ready), 64'd0);
    chk("t2_hold_addr", 64'(l2_addr), 64'h0000_0100);
    repeat (4) cyc(0, 0, 0, 1, 0);
    chk("t2_wb_cnt", 64'(wb_cnt), 64'd4);

    // outstanding limit stalls the third read
    cyc(0, 0, 0, 1, 1);
    cyc(1, 0, 32'h0000_A000, 1, 0);
    cyc(1, 0, 32'h0000_B000, 1, 0);
    cyc(1, 0, 32'h0000_C000, 1, 0);
    cyc(0, 0, 0, 1, 0);
    chk("t3_stall", 64'(l2_valid), 64'd0);
    cyc(0, 0, 0, 1, 1);
    chk("t3_fill_addr", 64'(fill_addr), 64'h0000_A000);
    chk("t3_issue", 64'(l2_valid), 64'd1);
    drain();

    // merge of a duplicate read, writeback kept
    cyc(1, 0, 32'h0000_1000, 0, 0);
    cyc(1, 0, 32'h0000_103C, 0, 0);
    cyc(1, 1, 32'h0000_1000, 0, 0);
    chk("t4_merge", 64'(merge_cnt), 64'd1);
    drain();

    // fill with nothing outstanding
    cyc(0, 0, 0, 0, 1);
    chk("t5_no_fill", 64'(fill_valid), 64'd0);
    chk("t5_err", 64'(err_fill), 64'd1);
    repeat (3) cyc(0, 0, 0, 0, 0);
    chk("t5_sticky", 64'(err_fill), 64'd1);

    // randomized traffic
    for (int n = 0; n < 1500; n++)
      cyc($urandom_range(0, 2) != 0,
          $urandom_range(0, 3) == 0, pick_addr(),
          $urandom_range(0, 3) != 0,
          outst.size() != 0 && $urandom_range(0, 2) == 0);
    drain();

    // reset in the middle of an issue
    cyc(1, 1, 32'h0000_5000, 0, 0);
    cyc(1, 0, 32'h0000_6000, 0, 0);
    cyc(1, 1, 32'h0000_7000, 0, 0);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_l2_valid", 64'(l2_valid), 64'd0);
    chk("t6_req_ready", 64'(req_ready), 64'd1);
    chk("t6_wb_cnt", 64'(wb_cnt), 64'd0);
    chk("t6_merge", 64'(merge_cnt), 64'd0);
    chk("t6_err", 64'(err_fill), 64'd0);
    cyc(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    for (int n = 0; n < 200; n++)
      cyc($urandom_range(0, 1) != 0,
          $urandom_range(0, 3) == 0, pick_addr(),
          $urandom_range(0, 1) != 0,
          outst.size() != 0 && $urandom_range(0, 1) == 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
